// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_unit
//  Purpose  : Front-end sequencer. Holds the PC, fetches instruction words
//             from instruction memory, issues them to decode, stalls on
//             branches/jumps until execute resolves them, halts on opcode 0.
//  Revision : 1.0  initial release
// ============================================================================
module instr_fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 60,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               issue_valid,
  input  logic               issue_ready,
  output logic [INSTR_W-1:0] issue_instr,
  output logic [3:0]         issue_opcode,
  output logic [ADDR_W-1:0]  issue_pc,
  input  logic               branch_en,
  input  logic               jump_en,
  input  logic               resolve_valid,
  input  logic               resolve_taken,
  input  logic [ADDR_W-1:0]  resolve_target,
  output logic               halted,
  output logic [31:0]        issue_count
);

  // Sequencer states
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FETCH   = 2'd1;
  localparam logic [1:0] S_ISSUE   = 2'd2;
  localparam logic [1:0] S_RESOLVE = 2'd3;

  localparam logic [3:0] OP_HALT   = 4'd0;

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] redirect_pc;
  logic              handshake;
  logic              is_halt;
  logic              is_ctrl;

  // The decoder sees the opcode field of the registered instruction directly
  assign issue_opcode = issue_instr[INSTR_W-1 -: 4];

  // Sequential PC wraps naturally at the top of the address space
  assign pc_inc      = pc + ADDR_W'(1);
  assign redirect_pc = resolve_taken ? resolve_target : pc_inc;
  assign handshake   = issue_valid & issue_ready;
  assign is_halt     = (issue_opcode == OP_HALT);
  assign is_ctrl     = branch_en | jump_en;

  // State machine; every output except issue_opcode is registered here and
  // is loaded together with the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      issue_valid <= 1'b0;
      issue_instr <= '0;
      issue_pc    <= '0;
      issue_count <= '0;
      halted      <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_FETCH;
            imem_req  <= 1'b1;
            imem_addr <= pc;
            halted    <= 1'b0;
          end
        end

        S_FETCH: begin
          // imem_addr is left untouched so it stays stable until the ack
          if (imem_ack) begin
            state       <= S_ISSUE;
            imem_req    <= 1'b0;
            issue_instr <= imem_rdata;
            issue_pc    <= pc;
            issue_valid <= 1'b1;
          end
        end

        S_ISSUE: begin
          if (handshake) begin
            issue_valid <= 1'b0;
            issue_count <= issue_count + 32'd1;
            if (is_halt) begin
              pc     <= pc_inc;
              state  <= S_IDLE;
              halted <= 1'b1;
            end else if (is_ctrl) begin
              // PC stays on the control-flow instruction until resolution
              state <= S_RESOLVE;
            end else begin
              pc        <= pc_inc;
              state     <= S_FETCH;
              imem_req  <= 1'b1;
              imem_addr <= pc_inc;
            end
          end
        end

        S_RESOLVE: begin
          if (resolve_valid) begin
            pc        <= redirect_pc;
            state     <= S_FETCH;
            imem_req  <= 1'b1;
            imem_addr <= redirect_pc;
          end
        end

        default: begin
          state    <= S_IDLE;
          imem_req <= 1'b0;
          halted   <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
